seven_seg_mux: RTL and testbench

SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

---
 rtl/seven_seg_pkg.sv | 53 +++++
 rtl/seven_seg_decode.sv | 13 +
 rtl/seven_seg_mux.sv | 147 ++++++++++++++
 tb/tb_seven_seg_mux.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment codes (abc_defg, bit 6 = a,
// bit 0 = g, active-high) for 0..F, the blank code and a decode function
// usable by any display block.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h73;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h47;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Nibble to segment code; values 10..15 are dark unless hex_mode is set.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] value,
                                                    input logic       hex_mode);
        logic [SEG_W-1:0] code;
        code = SEG_BLANK;
        case (value)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = hex_mode ? SEG_A : SEG_BLANK;
            4'hB: code = hex_mode ? SEG_B : SEG_BLANK;
            4'hC: code = hex_mode ? SEG_C : SEG_BLANK;
            4'hD: code = hex_mode ? SEG_D : SEG_BLANK;
            4'hE: code = hex_mode ? SEG_E : SEG_BLANK;
            4'hF: code = hex_mode ? SEG_F : SEG_BLANK;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational nibble-to-segment decoder.
// Ports: value (4-bit nibble), hex_mode (1 = show A..F), seg_c (abc_defg).
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0]       value,
    input  logic             hex_mode,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = seg_decode(value, hex_mode);

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment display driver with shadow data registers,
// optional hex decode, leading-zero suppression and pin polarity control.
// Ports: clk, rst (async active-high), enable, load, data (nibble per digit),
// dp_in, blank_mask; registered segments, dp_out, anodes, digit_idx.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned PRESCALE       = 1000,
    parameter bit          HEX_MODE       = 1'b1,
    parameter bit          LZ_SUPPRESS    = 1'b0,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b0,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [SEG_W-1:0]        segments,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned DAT_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt;
    logic [DAT_W-1:0]      data_q;
    logic [NUM_DIGITS-1:0] dp_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [SEG_W-1:0]      seg_q;
    logic                  dpo_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic                  tick_c;
    logic [IDX_W-1:0]      idx_next_c;
    logic [DAT_W-1:0]      data_next_c;
    logic [NUM_DIGITS-1:0] dp_next_c;
    logic [NUM_DIGITS-1:0] blank_next_c;
    logic [NUM_DIGITS-1:0] lz_c;
    logic [NUM_DIGITS-1:0] an_next_c;
    logic [3:0]            nib_c;
    logic                  dp_sel_c;
    logic                  blank_sel_c;
    logic [SEG_W-1:0]      dec_seg_c;

    assign tick_c = enable && (cnt == CNT_W'(PRESCALE - 1));

    // Next scan position; the output stage decodes this so it lines up with digit_idx.
    always_comb begin
        idx_next_c = digit_idx;
        if (tick_c) begin
            if (digit_idx == IDX_W'(NUM_DIGITS - 1)) idx_next_c = '0;
            else                                     idx_next_c = digit_idx + IDX_W'(1);
        end
    end

    // A load is visible to the output stage on the same edge it is captured.
    assign data_next_c  = load ? data       : data_q;
    assign dp_next_c    = load ? dp_in      : dp_q;
    assign blank_next_c = load ? blank_mask : blank_q;

    // Leading-zero mask: digit k is dark when it and every higher nibble is zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_c     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (data_next_c[4*k +: 4] == 4'h0);
            lz_c[k]  = LZ_SUPPRESS && (k > 0) && all_zero;
        end
    end

    // Select the nibble and attributes of the digit about to be driven.
    always_comb begin
        nib_c       = 4'h0;
        dp_sel_c    = 1'b0;
        blank_sel_c = 1'b0;
        an_next_c   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_next_c == IDX_W'(k)) begin
                nib_c        = data_next_c[4*k +: 4];
                dp_sel_c     = dp_next_c[k];
                blank_sel_c  = blank_next_c[k] | lz_c[k];
                an_next_c[k] = 1'b1;
            end
        end
    end

    seven_seg_decode u_decode (
        .value    (nib_c),
        .hex_mode (HEX_MODE),
        .seg_c    (dec_seg_c)
    );

    // Prescaler and scan position; both hold while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            digit_idx <= '0;
        end else begin
            if (enable) cnt <= tick_c ? '0 : cnt + CNT_W'(1);
            digit_idx <= idx_next_c;
        end
    end

    // Shadow display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (load) begin
            data_q  <= data;
            dp_q    <= dp_in;
            blank_q <= blank_mask;
        end
    end

    // Active-high output registers; a blanked digit keeps its anode on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            dpo_q <= 1'b0;
            an_q  <= '0;
        end else if (enable) begin
            seg_q <= blank_sel_c ? SEG_BLANK : dec_seg_c;
            dpo_q <= dp_sel_c && !blank_sel_c;
            an_q  <= an_next_c;
        end else begin
            seg_q <= SEG_BLANK;
            dpo_q <= 1'b0;
            an_q  <= '0;
        end
    end

    // Pin polarity.
    assign segments = seg_q ^ {SEG_W{SEG_ACTIVE_LOW}};
    assign dp_out   = dpo_q ^ SEG_ACTIVE_LOW;
    assign anodes   = an_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux: two instances share stimulus, one
// active-high hex display and one decimal, zero-suppressed, active-low display.
module tb_seven_seg_mux;

    localparam int unsigned ND = 4;
    localparam int unsigned PS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   data = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_mask = '0;

    logic [6:0]    seg_a, seg_b;
    logic          dp_a, dp_b;
    logic [3:0]    an_a, an_b;
    logic [1:0]    idx_a, idx_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: enabled-edge count since reset and shadow contents.
    int          en_count = 0;
    logic [15:0] sh_data  = '0;
    logic [3:0]  sh_dp    = '0;
    logic [3:0]  sh_bm    = '0;
    int          cur      = 0;
    logic [6:0]  e_seg_a, e_seg_b;
    logic        e_dp_a, e_dp_b;
    logic [3:0]  e_an_a, e_an_b;

    always #5 clk = ~clk;

    seven_seg_mux #(
        .NUM_DIGITS(ND), .PRESCALE(PS), .HEX_MODE(1'b1), .LZ_SUPPRESS(1'b0),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .data(data),
        .dp_in(dp_in), .blank_mask(blank_mask), .segments(seg_a),
        .dp_out(dp_a), .anodes(an_a), .digit_idx(idx_a)
    );

    seven_seg_mux #(
        .NUM_DIGITS(ND), .PRESCALE(PS), .HEX_MODE(1'b0), .LZ_SUPPRESS(1'b1),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .data(data),
        .dp_in(dp_in), .blank_mask(blank_mask), .segments(seg_b),
        .dp_out(dp_b), .anodes(an_b), .digit_idx(idx_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] code_of(input int v, input bit hex);
        case (v)
            0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
            4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
            8: return 7'h7F;  9: return 7'h73;
            10: return hex ? 7'h77 : 7'h00;
            11: return hex ? 7'h1F : 7'h00;
            12: return hex ? 7'h4E : 7'h00;
            13: return hex ? 7'h3D : 7'h00;
            14: return hex ? 7'h4F : 7'h00;
            default: return hex ? 7'h47 : 7'h00;
        endcase
    endfunction

    // Expected pins after a clock edge, from the display rules.
    task automatic model_edge();
        int  nib;
        bit  blk_a, blk_b;
        if (load) begin
            sh_data = data;
            sh_dp   = dp_in;
            sh_bm   = blank_mask;
        end
        if (enable) en_count++;
        cur = (en_count / PS) % ND;
        nib = int'((sh_data >> (4 * cur)) & 16'hF);
        blk_a = sh_bm[cur];
        blk_b = sh_bm[cur] || (cur > 0 && (sh_data >> (4 * cur)) == 16'h0);
        if (enable) begin
            e_seg_a = blk_a ? 7'h00 : code_of(nib, 1'b1);
            e_dp_a  = !blk_a && sh_dp[cur];
            e_an_a  = 4'(1 << cur);
            e_seg_b = ~(blk_b ? 7'h00 : code_of(nib, 1'b0));
            e_dp_b  = ~(!blk_b && sh_dp[cur]);
            e_an_b  = ~4'(1 << cur);
        end else begin
            e_seg_a = 7'h00; e_dp_a = 1'b0; e_an_a = 4'h0;
            e_seg_b = 7'h7F; e_dp_b = 1'b1; e_an_b = 4'hF;
        end
    endtask

    task automatic check_all();
        check("seg_a", 32'(seg_a), 32'(e_seg_a));
        check("dp_a",  32'(dp_a),  32'(e_dp_a));
        check("an_a",  32'(an_a),  32'(e_an_a));
        check("idx_a", 32'(idx_a), 32'(cur));
        check("seg_b", 32'(seg_b), 32'(e_seg_b));
        check("dp_b",  32'(dp_b),  32'(e_dp_b));
        check("an_b",  32'(an_b),  32'(e_an_b));
        check("idx_b", 32'(idx_b), 32'(cur));
    endtask

    task automatic model_reset();
        en_count = 0; sh_data = '0; sh_dp = '0; sh_bm = '0; cur = 0;
        e_seg_a = 7'h00; e_dp_a = 1'b0; e_an_a = 4'h0;
        e_seg_b = 7'h7F; e_dp_b = 1'b1; e_an_b = 4'hF;
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic en, input logic ld, input logic [15:0] d,
                        input logic [3:0] dp, input logic [3:0] bm);
        enable = en; load = ld; data = d; dp_in = dp; blank_mask = bm;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset mid-cycle, with a load pending that must be discarded.
    task automatic do_reset();
        #2;
        load = 1'b1; data = 16'($urandom); dp_in = 4'hF; blank_mask = 4'h0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Basic scan of 1234 with decimal points on digits 1 and 3.
        step(1'b1, 1'b1, 16'h1234, 4'b1010, 4'b0000);
        repeat (2 * ND * PS) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // Leading zeros on the decimal display.
        step(1'b1, 1'b1, 16'h0050, 4'h0, 4'h0);
        repeat (ND * PS) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // Hex digits A/B, blanked on the decimal display; digit 2 masked.
        step(1'b1, 1'b1, 16'hC0AB, 4'b0101, 4'b0100);
        repeat (ND * PS) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // Freeze during digit 2, then resume the remainder of the slot.
        for (int i = 0; i < 4 * ND * PS && cur != 2; i++)
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        check("reach_digit2", 32'(cur), 32'd2);
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        repeat (50) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 16'h9876, 4'h1, 4'h0);
        repeat (ND * PS) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // Reset mid-slot, then an all-zero display.
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        do_reset();
        repeat (ND * PS + 2) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 9) != 0),
                     1'($urandom_range(0, 7) == 0),
                     16'($urandom),
                     4'($urandom),
                     ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
